// File: rtl/mseq_sync_ctrl_pkg.sv
// rtl/mseq_sync_ctrl_pkg.sv - shared constants, state encoding and width helper for the M-sequence sync controller
package mseq_sync_ctrl_pkg;

  localparam int SEQ_LEN       = 31;
  localparam int CORR_W        = 8;
  localparam int DEF_PEAK_THR  = 62;
  localparam int DEF_CONFIRM_N = 3;
  localparam int DEF_MISS_MAX  = 2;

  function automatic int phase_w(input int len);
    return $clog2(len);
  endfunction

  localparam int PHASE_W = phase_w(SEQ_LEN);
  localparam int HIT_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCK   = 2'd3
  } state_e;

endpackage

// File: rtl/mseq_sync_ctrl_if.sv
// rtl/mseq_sync_ctrl_if.sv - correlator input and sync status bundle for the M-sequence sync controller
interface mseq_sync_ctrl_if;
  import mseq_sync_ctrl_pkg::*;

  logic               en;
  logic [CORR_W-1:0]  corr_data;
  logic [1:0]         state;
  logic               locked;
  logic [PHASE_W-1:0] chip_phase;
  logic               peak_hit;
  logic               frame_start;
  logic               lock_lost;
  logic [1:0]         miss_cnt;

  modport master (
    output en, corr_data,
    input  state, locked, chip_phase, peak_hit, frame_start, lock_lost, miss_cnt
  );

  modport slave (
    input  en, corr_data,
    output state, locked, chip_phase, peak_hit, frame_start, lock_lost, miss_cnt
  );

endinterface

// File: rtl/mseq_sync_ctrl_phase_cnt.sv
// rtl/mseq_sync_ctrl_phase_cnt.sv - mod-LEN chip phase counter with clear and due flag
module mseq_sync_ctrl_phase_cnt #(
  parameter int LEN = 31,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  output logic [W-1:0] phase,
  output logic         due
);

  logic [W-1:0] phase_q;
  logic [W-1:0] phase_d;

  assign due = (phase_q == W'(LEN - 1));

  // Wrap and clear both land on 0, so a peak on the due cycle needs no special case.
  always_comb begin
    phase_d = phase_q + W'(1);
    if (clr || due) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/mseq_sync_ctrl.sv
// rtl/mseq_sync_ctrl.sv - acquisition/tracking FSM: peak search, periodic confirm, flywheel lock
module mseq_sync_ctrl
  import mseq_sync_ctrl_pkg::*;
#(
  parameter int PEAK_THR  = DEF_PEAK_THR,
  parameter int CONFIRM_N = DEF_CONFIRM_N,
  parameter int MISS_MAX  = DEF_MISS_MAX
) (
  input logic              clk,
  input logic              rst_n,
  mseq_sync_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic [1:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             peak_hit_q, peak_hit_d;
  logic             frame_start_q, frame_start_d;
  logic             lock_lost_q, lock_lost_d;
  logic             peak;
  logic             due;
  logic             phase_clr;

  assign peak = (bus.corr_data >= CORR_W'(PEAK_THR));

  // Phase is pinned to 0 until acquisition, and re-anchored on any VERIFY peak; never slips in LOCK.
  assign phase_clr = !bus.en || (state_q == ST_IDLE) || (state_q == ST_SEARCH)
                     || ((state_q == ST_VERIFY) && peak);

  mseq_sync_ctrl_phase_cnt #(
    .LEN (SEQ_LEN),
    .W   (PHASE_W)
  ) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (phase_clr),
    .phase (bus.chip_phase),
    .due   (due)
  );

  always_comb begin
    state_d       = state_q;
    hits_d        = hits_q;
    miss_d        = miss_q;
    peak_hit_d    = 1'b0;
    frame_start_d = 1'b0;
    lock_lost_d   = 1'b0;
    if (!bus.en) begin
      state_d = ST_IDLE;
      hits_d  = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEARCH;
        ST_SEARCH: begin
          if (peak) begin
            state_d = ST_VERIFY;
            hits_d  = HIT_W'(1);
          end
        end
        ST_VERIFY: begin
          if (due && peak) begin
            peak_hit_d = 1'b1;
            if (hits_q + HIT_W'(1) == HIT_W'(CONFIRM_N)) begin
              state_d       = ST_LOCK;
              frame_start_d = 1'b1;
              hits_d        = '0;
              miss_d        = '0;
            end else begin
              hits_d = hits_q + HIT_W'(1);
            end
          end else if (due) begin
            state_d = ST_SEARCH;
            hits_d  = '0;
          end else if (peak) begin
            hits_d = HIT_W'(1);
          end
        end
        ST_LOCK: begin
          if (due && peak) begin
            peak_hit_d    = 1'b1;
            frame_start_d = 1'b1;
            miss_d        = '0;
          end else if (due) begin
            if (miss_q + 2'd1 == 2'(MISS_MAX)) begin
              state_d     = ST_SEARCH;
              lock_lost_d = 1'b1;
              miss_d      = '0;
            end else begin
              miss_d        = miss_q + 2'd1;
              frame_start_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hits_q        <= '0;
      miss_q        <= '0;
      locked_q      <= 1'b0;
      peak_hit_q    <= 1'b0;
      frame_start_q <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hits_q        <= hits_d;
      miss_q        <= miss_d;
      locked_q      <= locked_d;
      peak_hit_q    <= peak_hit_d;
      frame_start_q <= frame_start_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.locked      = locked_q;
  assign bus.peak_hit    = peak_hit_q;
  assign bus.frame_start = frame_start_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.miss_cnt    = miss_q;

endmodule

// File: tb/tb_mseq_sync_ctrl.sv
// tb/tb_mseq_sync_ctrl.sv - table/scoreboard bench for the M-sequence sync controller
module tb_mseq_sync_ctrl;
  import mseq_sync_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mseq_sync_ctrl_if bus();

  mseq_sync_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // -1 in any field means "not checked"
  typedef struct {
    int scn; int cyc; int st; int lk; int ph; int fs; int hit; int ll; int mc;
  } exp_t;

  exp_t tab[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(int scn, int cyc, int st, int lk, int ph,
                              int fs, int hit, int ll, int mc);
    exp_t e;
    e.scn = scn; e.cyc = cyc; e.st = st; e.lk = lk; e.ph = ph;
    e.fs = fs; e.hit = hit; e.ll = ll; e.mc = mc;
    return e;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e, input string tag);
    cmp({tag, " state"},       int'(bus.state),       e.st);
    cmp({tag, " locked"},      int'(bus.locked),      e.lk);
    cmp({tag, " chip_phase"},  int'(bus.chip_phase),  e.ph);
    cmp({tag, " frame_start"}, int'(bus.frame_start), e.fs);
    cmp({tag, " peak_hit"},    int'(bus.peak_hit),    e.hit);
    cmp({tag, " lock_lost"},   int'(bus.lock_lost),   e.ll);
    cmp({tag, " miss_cnt"},    int'(bus.miss_cnt),    e.mc);
  endtask

  function automatic int corr_for(int id, int c);
    case (id)
      2: return (c inside {5, 36, 67, 98, 129}) ? 62 : 10;
      3: return (c inside {5, 36, 67, 129}) ? 62 : 10;
      4: return (c inside {5, 36, 67}) ? 62 : 10;
      5: return (c == 5) ? 62 : (c == 36) ? 61 : 10;
      6: return (c inside {5, 15, 46}) ? 62 : 10;
      7: return (c inside {5, 36, 67}) ? 62 : (c == 80) ? 255 : (c == 98) ? 200 : 10;
      8: return (c inside {5, 36, 67, 98}) ? 62 : 10;
      default: return 0;
    endcase
  endfunction

  task automatic do_reset(input string tag);
    exp_t e;
    bus.en        = 1'b0;
    bus.corr_data = '0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_outputs(e, tag);
    rst_n = 1'b1;
  endtask

  task automatic run_scn(input int id, input int ncyc, input int en_off);
    exp_t e;
    foreach (tab[i]) if (tab[i].scn == id && tab[i].cyc <= ncyc) sb.push_back(tab[i]);
    for (int c = 0; c <= ncyc; c++) begin
      bus.en        = (en_off < 0 || c < en_off) ? 1'b1 : 1'b0;
      bus.corr_data = CORR_W'(corr_for(id, c));
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        check_outputs(e, $sformatf("scn%0d cyc%0d", id, c));
      end
    end
    cmp($sformatf("scn%0d scoreboard leftover", id), sb.size(), 0);
    sb.delete();
  endtask

  logic [30:0] pat = 31'b0011001001111101110001010110100;
  logic [30:0] win;

  initial begin
    int found;
    int fs_cnt;
    int lk_cyc;
    int idx;
    logic chip;

    //        scn cyc st lk ph fs hit ll mc
    tab.push_back(mk(2,   0, 1, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(2,   4, 1, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(2,   5, 2, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(2,  35, 2, 0, 30, 0, 0, 0, 0));
    tab.push_back(mk(2,  36, 2, 0,  0, 0, 1, 0, 0));
    tab.push_back(mk(2,  37, 2, 0,  1, 0, 0, 0, 0));
    tab.push_back(mk(2,  67, 3, 1,  0, 1, 1, 0, 0));
    tab.push_back(mk(2,  68, 3, 1,  1, 0, 0, 0, 0));
    tab.push_back(mk(2,  97, 3, 1, 30, 0, 0, 0, 0));
    tab.push_back(mk(2,  98, 3, 1,  0, 1, 1, 0, 0));
    tab.push_back(mk(2, 129, 3, 1,  0, 1, 1, 0, 0));
    tab.push_back(mk(3,  98, 3, 1,  0, 1, 0, 0, 1));
    tab.push_back(mk(3,  99, 3, 1,  1, 0, 0, 0, 1));
    tab.push_back(mk(3, 129, 3, 1,  0, 1, 1, 0, 0));
    tab.push_back(mk(4,  98, 3, 1,  0, 1, 0, 0, 1));
    tab.push_back(mk(4, 129, 1, 0,  0, 0, 0, 1, 0));
    tab.push_back(mk(4, 130, 1, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(5,  36, 1, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(5,  37, 1, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(6,  15, 2, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(6,  36, 2, 0, 21, 0, 0, 0, 0));
    tab.push_back(mk(6,  45, 2, 0, 30, 0, 0, 0, 0));
    tab.push_back(mk(6,  46, 2, 0,  0, 0, 1, 0, 0));
    tab.push_back(mk(7,  80, 3, 1, 13, 0, 0, 0, 0));
    tab.push_back(mk(7,  98, 3, 1,  0, 1, 1, 0, 0));
    tab.push_back(mk(8,  74, 3, 1,  7, 0, 0, 0, 0));
    tab.push_back(mk(8,  75, 0, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(8,  76, 0, 0,  0, 0, 0, 0, 0));

    do_reset("reset0");
    run_scn(2, 135, -1);
    do_reset("reset2");
    run_scn(3, 135, -1);
    do_reset("reset3");
    run_scn(4, 135, -1);
    do_reset("reset4");
    run_scn(5, 40, -1);
    do_reset("reset5");
    run_scn(6, 50, -1);
    do_reset("reset6");
    run_scn(7, 100, -1);
    do_reset("reset7");
    run_scn(8, 80, 75);

    // Asynchronous reset in the middle of LOCK, checked before the next clock edge
    do_reset("reset8");
    run_scn(4, 70, -1);
    cmp("pre_async_reset locked", int'(bus.locked), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // End to end: behavioural correlator over the M-sequence chip stream
    do_reset("reset9");
    win    = '0;
    found  = -1;
    fs_cnt = 0;
    lk_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      idx  = 30 - (k % 31);
      chip = pat[idx];
      win  = {win[29:0], chip};
      bus.en        = 1'b1;
      bus.corr_data = CORR_W'(2 * (31 - $countones(win ^ pat)));
      @(posedge clk);
      #1;
      if (found < 0 && bus.locked) begin
        found  = k;
        lk_cyc = k;
        cmp("mseq lock frame_start", int'(bus.frame_start), 1);
        cmp("mseq lock chip_phase", int'(bus.chip_phase), 0);
      end else if (found >= 0 && k > lk_cyc && k <= lk_cyc + 31) begin
        fs_cnt += int'(bus.frame_start);
      end
    end
    cmp("mseq locked within 4 periods", (found >= 0 && found < 4 * SEQ_LEN) ? 1 : 0, 1);
    cmp("mseq frame_start per period", fs_cnt, 1);
    cmp("mseq still locked", int'(bus.locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
